// File: rtl/vm_pkg.sv
// rtl/vm_pkg.sv - shared coin constants and index type for the vending machine front end
package vm_pkg;

    localparam int COIN_W = 3;

    localparam logic [COIN_W-1:0] COIN_R1 = 3'd1;
    localparam logic [COIN_W-1:0] COIN_R2 = 3'd2;
    localparam logic [COIN_W-1:0] COIN_R5 = 3'd5;

    typedef enum logic [1:0] {
        IDX_R1 = 2'd0,
        IDX_R2 = 2'd1,
        IDX_R5 = 2'd2
    } coin_idx_t;

    function automatic logic [COIN_W-1:0] coin_value_of(input coin_idx_t idx);
        case (idx)
            IDX_R1:  coin_value_of = COIN_R1;
            IDX_R2:  coin_value_of = COIN_R2;
            IDX_R5:  coin_value_of = COIN_R5;
            default: coin_value_of = '0;
        endcase
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// rtl/debounce_ch.sv - one button channel: two-flop synchroniser, sample-gated debounce, rise pulse
module debounce_ch #(
    parameter int DB_COUNT = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sample_en,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam logic [7:0] LIMIT = 8'(DB_COUNT);

    logic       sync_a;
    logic       sync_b;
    logic       db;
    logic       db_q;
    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            db     <= 1'b0;
            db_q   <= 1'b0;
            cnt    <= '0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
            db_q   <= db;
            if (sample_en) begin
                // Only an unbroken run of mismatching samples may flip the level.
                if (sync_b != db) begin
                    if (cnt + 8'd1 == LIMIT) begin
                        db  <= ~db;
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end else begin
                    cnt <= '0;
                end
            end
        end
    end

    assign level = db;
    assign rise  = db & ~db_q;

endmodule

// File: rtl/coin_conditioner.sv
// rtl/coin_conditioner.sv - debounced coin buttons to a prioritised valid/ready coin event stream
module coin_conditioner
    import vm_pkg::*;
#(
    parameter int DB_COUNT = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sample_en,
    input  logic              r1_raw,
    input  logic              r2_raw,
    input  logic              r5_raw,
    input  logic              coin_ready,
    output logic              coin_valid,
    output logic [COIN_W-1:0] coin_value,
    output logic [2:0]        pressed,
    output logic              overflow,
    input  logic              clr_overflow
);

    logic [2:0] raw;
    logic [2:0] rise;
    logic [2:0] pend;
    logic [2:0] pend_next;
    logic [2:0] drain;
    logic [2:0] drop;
    logic       free;
    logic       has_pend;
    coin_idx_t  sel;

    assign raw = {r5_raw, r2_raw, r1_raw};

    for (genvar i = 0; i < 3; i++) begin : g_ch
        debounce_ch #(.DB_COUNT(DB_COUNT)) u_ch (
            .clk       (clk),
            .reset_n   (reset_n),
            .sample_en (sample_en),
            .raw       (raw[i]),
            .level     (pressed[i]),
            .rise      (rise[i])
        );
    end

    assign free     = !coin_valid || coin_ready;
    assign has_pend = |pend;

    always_comb begin
        sel = IDX_R5;
        if (pend[0])      sel = IDX_R1;
        else if (pend[1]) sel = IDX_R2;
    end

    // A press landing on a bit that is drained the same cycle simply re-arms it.
    always_comb begin
        drain = '0;
        if (free && has_pend) drain = 3'b001 << sel;
        pend_next = rise | (pend & ~drain);
        drop      = rise & pend & ~drain;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pend       <= '0;
            coin_valid <= 1'b0;
            coin_value <= '0;
            overflow   <= 1'b0;
        end else begin
            pend <= pend_next;
            if (|drop)             overflow <= 1'b1;
            else if (clr_overflow) overflow <= 1'b0;
            if (free) begin
                if (has_pend) begin
                    coin_valid <= 1'b1;
                    coin_value <= coin_value_of(sel);
                end else begin
                    coin_valid <= 1'b0;
                    coin_value <= '0;
                end
            end
        end
    end

endmodule

// File: doc/coin_conditioner.md
# coin_conditioner

Front-end stage of the vending machine: takes the three raw coin push-buttons (Rs 1, Rs 2, Rs 5), synchronises and debounces each one, and turns every clean press into exactly one coin event. Events reach the money collector over a valid/ready handshake. Presses that arrive close together, or at the same time, are held in per-coin pending flags, so none are lost under normal use. The collector adds `coin_value` to its running total once per accepted event.

## Interface
Parameters:
- `DB_COUNT`, default 16: number of consecutive sampled mismatches needed to flip a debounced level. Legal range is 1..255.

Ports:
- `clk` in 1: the single system clock.
- `reset_n` in 1: reset, synchronous, active-low.
- `sample_en` in 1: debounce sample strobe, one cycle wide. Tie it high to sample on every clock.
- `r1_raw`, `r2_raw`, `r5_raw` in 1 each: raw asynchronous buttons, active-high.
- `coin_ready` in 1: the collector accepts the current event.
- `coin_valid` out 1: an event is being presented.
- `coin_value` out 3: 3'd1, 3'd2 or 3'd5 while `coin_valid` is high, 3'd0 otherwise.
- `pressed` out 3: debounced levels, ordered {r5, r2, r1}.
- `overflow` out 1: sticky flag, set when a press is dropped.
- `clr_overflow` in 1: clears `overflow`.

## Operation
Per-coin channel:
- Two-flop synchroniser feeds `sync`.
- The debounced level `db` resets to 0, and the counter `cnt` resets to 0.
- On each clock with `sample_en` high:
  - If `sync` != `db`, `cnt` increments. When the increment reaches `DB_COUNT`, `db` toggles and `cnt` returns to 0.
  - If `sync` == `db`, `cnt` returns to 0.
- With `sample_en` low, `cnt` and `db` hold their values.
- A rising edge of `db` (a 0→1 flip) is a press. Falling edges produce no event.

Pending flags (`pend[2:0]`):
- A press sets its coin's `pend` bit on the next clock.
- A press arriving while that coin's `pend` bit is already set, and the bit is not being drained that same cycle, is dropped and sets `overflow`.
- If a set and a drain hit the same bit in the same cycle, the set wins: the bit stays 1 and no overflow is flagged.

Output register:
- The register is free when `coin_valid` is low, or when `coin_valid` and `coin_ready` are both high.
- When free and any `pend` bit is set, it loads the highest-priority pending coin and clears that bit on the same clock. Priority is r1 > r2 > r5, matching the collector.
- When free and nothing is pending, `coin_valid` goes low.
- While `coin_valid` is high and `coin_ready` is low, `coin_value` holds stable.

Overflow:
- `overflow` is sticky.
- `clr_overflow` clears it. If a new drop occurs in the same cycle as the clear, the set wins.

Reset (`reset_n` low at a clock edge):
- All of the following go to 0: synchronisers, `db`, `cnt`, `pend`, `coin_valid`, `coin_value`, `pressed`, `overflow`.
- This holds mid-debounce and mid-handshake. An event being presented is discarded.
- A button still held after reset releases is treated as a new press once it has debounced.

## Timing
Press latency, counting edge 0 as the edge whose synchroniser first captures the raw high, with `sample_en` tied high and the output idle:
- `sync` is high after edge 1.
- Mismatch samples occur at edges 2..`DB_COUNT`+1.
- `db` / `pressed` go high after edge `DB_COUNT`+1.
- `pend` is set after edge `DB_COUNT`+2.
- `coin_valid` goes high after edge `DB_COUNT`+3.

Release latency is identical in form but produces no event.

Throughput and handshake:
- Throughput is one event per clock while `coin_ready` is held high.
- `coin_valid` never drops without acceptance, except on reset.
- A bounce shorter than `DB_COUNT` consecutive samples never changes `db`.

## Structure
Package `vm_pkg`:
- Constants `COIN_R1`=3'd1, `COIN_R2`=3'd2, `COIN_R5`=3'd5.
- Coin index enum {`IDX_R1`, `IDX_R2`, `IDX_R5`}.
- `COIN_W`=3.

Sub-module `debounce_ch`:
- Contains the synchroniser, `cnt` and `db` for one channel.
- Outputs `level` and `rise`.
- Instantiated three times.

Pending flags, priority select, the output register and overflow logic live in the top level.

## Test plan
All scenarios use `DB_COUNT`=4 and `sample_en`=1.
- **Clean press:** raise `r2_raw`, hold `coin_ready`=1 → `coin_valid` is high for exactly one cycle, after edge 7, with `coin_value`=2. Nothing further until release and a new press.
- **Bounce rejection:** toggle `r5_raw` high 3 cycles, low 1, high 2, low → no event, `pressed`[2] stays 0. Then hold it high for 6 cycles → exactly one event, value 5.
- **Simultaneous press:** raise all three raws on the same cycle with `coin_ready`=1 → events come out on consecutive cycles in the order 1, 2, 5, with no overflow.
- **Backpressure:** hold `coin_ready`=0 and press r1 → `coin_valid` holds with `coin_value` 1 stable for 10 cycles. Press r1 again → `pend`[0] is set, no overflow. Press r1 a third time → `overflow`=1. Raise `coin_ready` → exactly two r1 events are delivered.
- **Reset mid-operation:** pull `reset_n` low while `coin_valid`=1 and r2 is pending → on the next edge all outputs are 0 and the pending event is lost. Release reset with r5 held → a single value-5 event appears after edge 7.
- **sample_en gating:** pulse `sample_en` once every 4 clocks → press latency stretches to 2 + 4 sampled ticks + 2 clocks. Check against a reference count.
